// File: rtl/codec_cfg_pkg.sv
// Shared types and the default codec register table for the init sequencer.
package codec_cfg_pkg;

    // Sequencer FSM states.
    typedef enum logic [2:0] {
        StIdle = 3'd0,
        StLoad = 3'd1,
        StReq  = 3'd2,
        StWait = 3'd3,
        StGap  = 3'd4,
        StFin  = 3'd5,
        StErr  = 3'd6
    } state_e;

    // One table entry: codec register byte and the data byte written to it.
    typedef struct packed {
        logic [7:0] register;
        logic [7:0] data;
    } entry_t;

    localparam int unsigned DEFAULT_TABLE_LEN = 10;

    // Default bring-up table; indices past the table read back as zero.
    function automatic entry_t table_entry(input logic [7:0] idx);
        entry_t e;
        case (idx)
            8'd0:    e = '{register: 8'h1E, data: 8'h00}; // soft reset
            8'd1:    e = '{register: 8'h00, data: 8'h17}; // left line in
            8'd2:    e = '{register: 8'h02, data: 8'h17}; // right line in
            8'd3:    e = '{register: 8'h04, data: 8'h79}; // left headphone
            8'd4:    e = '{register: 8'h06, data: 8'h79}; // right headphone
            8'd5:    e = '{register: 8'h08, data: 8'h12}; // analog path
            8'd6:    e = '{register: 8'h0A, data: 8'h00}; // digital path
            8'd7:    e = '{register: 8'h0C, data: 8'h00}; // power down ctrl
            8'd8:    e = '{register: 8'h0E, data: 8'h42}; // digital iface
            8'd9:    e = '{register: 8'h12, data: 8'h01}; // activate
            default: e = '0;
        endcase
        return e;
    endfunction

endpackage

// File: rtl/codec_init_rom.sv
// Synchronous-read table ROM: one cycle from index to entry.
module codec_init_rom
    import codec_cfg_pkg::*;
#(
    parameter int unsigned N_ENTRIES = 10
) (
    input  logic       clk_i,
    input  logic [7:0] idx_i,
    output entry_t     entry_o
);

    entry_t entry_q;

    // Registered read; out-of-range indices return an all-zero entry.
    always_ff @(posedge clk_i) begin
        if (32'(idx_i) < N_ENTRIES) begin
            entry_q <= table_entry(idx_i);
        end else begin
            entry_q <= '0;
        end
    end

    assign entry_o = entry_q;

endmodule

// File: rtl/codec_init_seq.sv
// Codec init sequencer: walks the register table, issuing one I2C write per
// entry with an idle gap between writes and a per-write completion timeout.
module codec_init_seq
    import codec_cfg_pkg::*;
#(
    parameter logic [6:0]  DEV_ADDR       = 7'h1A,
    parameter int unsigned N_ENTRIES      = 10,
    parameter int unsigned GAP_CYCLES     = 1000,
    parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
    input  logic       sys_clk,
    input  logic       reset,
    input  logic       start,
    output logic       busy,
    output logic       done,
    output logic       error,
    output logic [7:0] err_idx,
    output logic [6:0] addr,
    output logic [7:0] register,
    output logic [7:0] data,
    output logic       write,
    input  logic       wr_done
);

    localparam logic [7:0]  IDX_LAST = 8'(N_ENTRIES - 1);
    localparam logic [32:0] TO_LAST  = 33'(TIMEOUT_CYCLES) - 33'd1;
    localparam logic [31:0] GAP_LAST = 32'(GAP_CYCLES) - 32'd1;
    localparam bit          SKIP_GAP = (GAP_CYCLES == 0);

    state_e      state_q, state_d;
    logic [7:0]  idx_q, idx_d;
    logic        busy_q, busy_d;
    logic        error_q, error_d;
    logic [7:0]  err_idx_q, err_idx_d;
    logic [6:0]  addr_q, addr_d;
    logic [7:0]  register_q, register_d;
    logic [7:0]  data_q, data_d;
    logic [31:0] timer_q, timer_d;
    logic [31:0] gap_q, gap_d;
    logic        arm_q;
    entry_t      rom_entry;
    logic        timer_term;
    logic [31:0] timer_inc;

    // ROM is addressed with next-state idx so the entry is ready by the end of LOAD.
    codec_init_rom #(
        .N_ENTRIES(N_ENTRIES)
    ) u_rom (
        .clk_i  (sys_clk),
        .idx_i  (idx_d),
        .entry_o(rom_entry)
    );

    assign timer_term = ({1'b0, timer_q} + 33'd1) >= TO_LAST;
    assign timer_inc  = (timer_q == 32'hFFFF_FFFF) ? timer_q : timer_q + 32'd1;

    // Next-state and datapath update for the sequencer.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        busy_d     = busy_q;
        error_d    = error_q;
        err_idx_d  = err_idx_q;
        addr_d     = addr_q;
        register_d = register_q;
        data_d     = data_q;
        timer_d    = timer_q;
        gap_d      = gap_q;
        case (state_q)
            StIdle: begin
                // arm_q keeps start from being taken on the first edge after reset.
                if (start && arm_q) begin
                    idx_d   = 8'd0;
                    error_d = 1'b0;
                    busy_d  = 1'b1;
                    state_d = StLoad;
                end
            end
            StLoad: begin
                addr_d     = DEV_ADDR;
                register_d = rom_entry.register;
                data_d     = rom_entry.data;
                state_d    = StReq;
            end
            StReq: begin
                timer_d = 32'd0;
                state_d = StWait;
            end
            StWait: begin
                // Completion takes priority over a coincident timeout.
                if (wr_done) begin
                    if (idx_q == IDX_LAST) begin
                        state_d = StFin;
                    end else begin
                        idx_d   = idx_q + 8'd1;
                        gap_d   = 32'd0;
                        state_d = SKIP_GAP ? StLoad : StGap;
                    end
                end else begin
                    timer_d = timer_inc;
                    if (timer_term) begin
                        state_d = StErr;
                    end
                end
            end
            StGap: begin
                if (gap_q == GAP_LAST) begin
                    state_d = StLoad;
                end else begin
                    gap_d = gap_q + 32'd1;
                end
            end
            StFin: begin
                busy_d  = 1'b0;
                state_d = StIdle;
            end
            StErr: begin
                error_d   = 1'b1;
                err_idx_d = idx_q;
                busy_d    = 1'b0;
                state_d   = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // State registers with asynchronous reset.
    always_ff @(posedge sys_clk or posedge reset) begin
        if (reset) begin
            state_q    <= StIdle;
            idx_q      <= 8'd0;
            busy_q     <= 1'b0;
            error_q    <= 1'b0;
            err_idx_q  <= 8'd0;
            addr_q     <= 7'd0;
            register_q <= 8'd0;
            data_q     <= 8'd0;
            timer_q    <= 32'd0;
            gap_q      <= 32'd0;
            arm_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            busy_q     <= busy_d;
            error_q    <= error_d;
            err_idx_q  <= err_idx_d;
            addr_q     <= addr_d;
            register_q <= register_d;
            data_q     <= data_d;
            timer_q    <= timer_d;
            gap_q      <= gap_d;
            arm_q      <= 1'b1;
        end
    end

    assign write    = (state_q == StReq);
    assign done     = (state_q == StFin);
    assign busy     = busy_q;
    assign error    = error_q;
    assign err_idx  = err_idx_q;
    assign addr     = addr_q;
    assign register = register_q;
    assign data     = data_q;

endmodule
